// File: rtl/python_sync_encoder.sv
// PYTHON LVDS transmit encoder: frames AXI4-Stream pixel beats into sync-lane + data-lane words.
// One registered word per aclk. Underruns repeat the previous data word and never produce an output bubble.
module python_sync_encoder #(
  parameter int                   LANES      = 4,
  parameter int                   DATA_BITS  = 10,
  parameter int                   INIT_TRAIN = 2000,
  parameter int                   H_BLANK    = 67,
  parameter int                   V_BLANK    = 256,
  parameter logic [DATA_BITS-1:0] TR_CODE    = 10'h3a6,
  parameter logic [DATA_BITS-1:0] FS_CODE    = 10'h2aa,
  parameter logic [DATA_BITS-1:0] LS_CODE    = 10'h0aa,
  parameter logic [DATA_BITS-1:0] LE_CODE    = 10'h12a,
  parameter logic [DATA_BITS-1:0] FE_CODE    = 10'h3aa,
  parameter logic [DATA_BITS-1:0] IMG_CODE   = 10'h035,
  parameter logic [DATA_BITS-1:0] ID_CODE    = 10'h000,
  parameter logic [DATA_BITS-1:0] CRC_CODE   = 10'h059
) (
  input  logic                       aresetn,
  input  logic                       aclk,
  input  logic                       enable,
  input  logic [15:0]                param_width,
  input  logic [15:0]                param_height,
  input  logic                       s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [LANES*DATA_BITS-1:0] s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       s_axi4s_tready,
  output logic [LANES*DATA_BITS-1:0] m_data,
  output logic [DATA_BITS-1:0]       m_sync,
  output logic                       busy,
  output logic                       underrun,
  output logic                       tlast_error
);

  localparam int DW = LANES * DATA_BITS;
  localparam logic [DW-1:0] TR_WORD = {LANES{TR_CODE}};

  typedef enum logic [2:0] {S_INIT, S_VBLANK, S_LINE, S_CRC, S_HBLANK} state_t;

  state_t         state, state_n;
  logic [15:0]    cnt, cnt_n;
  logic [15:0]    w, w_n;
  logic [15:0]    line, line_n;
  logic [15:0]    width_r, width_n;
  logic [15:0]    height_r, height_n;
  logic [DW-1:0]  data_n;
  logic [DATA_BITS-1:0] sync_n;
  logic           busy_n, underrun_n, tlast_error_n;
  logic           beat, last_w;

  function automatic logic [DATA_BITS-1:0] sync_code(input logic [15:0] wi, input logic [15:0] ln,
                                                    input logic [15:0] wd, input logic [15:0] ht);
    if (wi == 16'd0) return (ln == 16'd0) ? FS_CODE : LS_CODE;
    if (wi == 16'd1 || wi == wd - 16'd1) return ID_CODE;
    if (wi == wd - 16'd2) return (ln == ht - 16'd1) ? FE_CODE : LE_CODE;
    return IMG_CODE;
  endfunction

  // cnt doubles as the training-word counter in INIT, VBLANK and HBLANK
  always_comb begin
    s_axi4s_tready = 1'b0;
    case (state)
      S_VBLANK: s_axi4s_tready = enable && (cnt >= 16'(V_BLANK));
      S_HBLANK: s_axi4s_tready = (cnt >= 16'(H_BLANK));
      S_LINE:   s_axi4s_tready = 1'b1;
      default:  s_axi4s_tready = 1'b0;
    endcase
  end

  assign beat   = s_axi4s_tvalid & s_axi4s_tready;
  assign last_w = (w == width_r - 16'd1);

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    w_n           = w;
    line_n        = line;
    width_n       = width_r;
    height_n      = height_r;
    data_n        = TR_WORD;
    sync_n        = TR_CODE;
    busy_n        = 1'b0;
    underrun_n    = underrun;
    tlast_error_n = tlast_error;
    case (state)
      S_INIT: begin
        if (cnt == 16'(INIT_TRAIN - 1)) begin
          state_n = S_VBLANK;
          cnt_n   = 16'(V_BLANK);
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_VBLANK: begin
        if (beat && s_axi4s_tuser) begin
          width_n       = param_width;
          height_n      = param_height;
          line_n        = 16'd0;
          w_n           = 16'd1;
          data_n        = s_axi4s_tdata;
          sync_n        = FS_CODE;
          busy_n        = 1'b1;
          tlast_error_n = tlast_error | s_axi4s_tlast;
          state_n       = S_LINE;
        end else if (cnt < 16'(V_BLANK)) begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_HBLANK: begin
        busy_n = 1'b1;
        if (beat) begin
          w_n           = 16'd1;
          data_n        = s_axi4s_tdata;
          sync_n        = sync_code(16'd0, line, width_r, height_r);
          tlast_error_n = tlast_error | s_axi4s_tlast;
          state_n       = S_LINE;
        end else if (cnt < 16'(H_BLANK)) begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_LINE: begin
        busy_n = 1'b1;
        sync_n = sync_code(w, line, width_r, height_r);
        if (s_axi4s_tvalid) begin
          data_n = s_axi4s_tdata;
          if (s_axi4s_tlast != last_w) tlast_error_n = 1'b1;
        end else begin
          data_n     = m_data;
          underrun_n = 1'b1;
        end
        if (last_w) begin
          w_n     = 16'd0;
          state_n = S_CRC;
        end else begin
          w_n = w + 16'd1;
        end
      end
      S_CRC: begin
        busy_n = 1'b1;
        data_n = {DW{1'b1}};
        sync_n = CRC_CODE;
        cnt_n  = 16'd0;
        if (line == height_r - 16'd1) begin
          line_n  = 16'd0;
          state_n = S_VBLANK;
        end else begin
          line_n  = line + 16'd1;
          state_n = S_HBLANK;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_INIT;
      cnt         <= 16'd0;
      w           <= 16'd0;
      line        <= 16'd0;
      width_r     <= 16'd0;
      height_r    <= 16'd0;
      m_data      <= TR_WORD;
      m_sync      <= TR_CODE;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      tlast_error <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      w           <= w_n;
      line        <= line_n;
      width_r     <= width_n;
      height_r    <= height_n;
      m_data      <= data_n;
      m_sync      <= sync_n;
      busy        <= busy_n;
      underrun    <= underrun_n;
      tlast_error <= tlast_error_n;
    end
  end

endmodule

// File: tb/tb_python_sync_encoder.sv
// Directed bench for python_sync_encoder: framing, drop-before-start, underrun, tlast errors, reset.
module tb_python_sync_encoder;

  localparam logic [9:0]  TR  = 10'h3a6;
  localparam logic [9:0]  FS  = 10'h2aa;
  localparam logic [9:0]  LS  = 10'h0aa;
  localparam logic [9:0]  LE  = 10'h12a;
  localparam logic [9:0]  FE  = 10'h3aa;
  localparam logic [9:0]  IMG = 10'h035;
  localparam logic [9:0]  ID  = 10'h000;
  localparam logic [9:0]  CRC = 10'h059;
  localparam logic [39:0] TR4 = {4{TR}};
  localparam logic [39:0] ONES = {40{1'b1}};

  localparam logic [9:0] SYNC_FIRST [8] = '{FS, ID, IMG, IMG, IMG, IMG, LE, ID};
  localparam logic [9:0] SYNC_LAST  [8] = '{LS, ID, IMG, IMG, IMG, IMG, FE, ID};
  localparam logic [9:0] SYNC_ONLY  [8] = '{FS, ID, IMG, IMG, IMG, IMG, FE, ID};
  localparam int         UND_IDX    [8] = '{0, 1, 2, 2, 2, 3, 4, 5};

  logic        aresetn, aclk, enable;
  logic [15:0] param_width, param_height;
  logic        tuser, tlast, tvalid, tready;
  logic [39:0] tdata, m_data;
  logic [9:0]  m_sync;
  logic        busy, underrun, tlast_error;

  int checks = 0;
  int errors = 0;

  logic [39:0] b_dat  [32];
  logic        b_user [32];
  logic        b_last [32];
  int          b_gap  [32];

  logic        cap_on = 1'b0;
  logic [9:0]  cs [$];
  logic [39:0] cd [$];
  logic        cb [$];

  python_sync_encoder dut (
    .aresetn(aresetn), .aclk(aclk), .enable(enable),
    .param_width(param_width), .param_height(param_height),
    .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tdata(tdata),
    .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready),
    .m_data(m_data), .m_sync(m_sync), .busy(busy),
    .underrun(underrun), .tlast_error(tlast_error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (cap_on) begin
      cs.push_back(m_sync);
      cd.push_back(m_data);
      cb.push_back(busy);
    end
  end

  function automatic logic [39:0] mk(input int i);
    return {10'(4*i+4), 10'(4*i+3), 10'(4*i+2), 10'(4*i+1)};
  endfunction

  function automatic int find_sync(input int start, input logic [9:0] v);
    for (int j = start; j < cs.size(); j++) if (cs[j] == v) return j;
    return -1;
  endfunction

  task automatic set_beats(input int n, input int line_len);
    for (int i = 0; i < n; i++) begin
      b_dat[i]  = mk(i);
      b_user[i] = (i == 0);
      b_last[i] = ((i % line_len) == line_len - 1);
      b_gap[i]  = 0;
    end
  endtask

  task automatic start_cap();
    cs.delete(); cd.delete(); cb.delete();
    cap_on = 1'b1;
  endtask

  // entry/exit time is 1 unit after a rising edge
  task automatic drive(input int n);
    logic acc;
    int   t;
    for (int i = 0; i < n; i++) begin
      if (b_gap[i] > 0) begin
        tvalid = 1'b0;
        repeat (b_gap[i]) begin @(posedge aclk); #1; end
      end
      tdata = b_dat[i]; tuser = b_user[i]; tlast = b_last[i]; tvalid = 1'b1;
      acc = 1'b0; t = 0;
      while (!acc && t < 2000) begin
        #1 acc = tready;
        @(posedge aclk); #1;
        t++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL drive_timeout: beat %0d not accepted after %0d cycles, required acceptance", i, t);
      end
    end
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    aresetn = 1'b0; tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    n = 0;
    while (!tready && n < 2200) begin @(posedge aclk); #1; n++; end
    if (!tready) begin
      checks++; errors++;
      $display("FAIL reset_ready_timeout: tready=%0b after %0d cycles, required 1", tready, n);
    end
  endtask

  task automatic test_reset();
    int n, first, bad;
    aresetn = 1'b0; enable = 1'b0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
    param_width = 16'd8; param_height = 16'd2;
    repeat (3) @(posedge aclk);
    #1;
    checks++; if (m_sync !== TR) begin errors++; $display("FAIL rst_sync: got %h required %h", m_sync, TR); end
    checks++; if (m_data !== TR4) begin errors++; $display("FAIL rst_data: got %h required %h", m_data, TR4); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b required 0", tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b required 0", underrun); end
    checks++; if (tlast_error !== 1'b0) begin errors++; $display("FAIL rst_tlast_error: got %b required 0", tlast_error); end
    @(negedge aclk); aresetn = 1'b1; enable = 1'b1;
    first = -1; bad = 0;
    for (n = 1; n <= 2100; n++) begin
      @(posedge aclk); #1;
      if (m_sync !== TR || m_data !== TR4) bad++;
      if (tready === 1'b1 && first < 0) first = n;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_training: %0d non-training words, required 0", bad); end
    checks++;
    if (first < 2000 || first > 2001) begin
      errors++; $display("FAIL init_length: tready first high at cycle %0d, required 2000..2001", first);
    end
  endtask

  task automatic test_frame();
    int f, g, l;
    param_width = 16'd8; param_height = 16'd2;
    set_beats(16, 8);
    start_cap();
    drive(16);
    repeat (20) begin @(posedge aclk); #1; end
    cap_on = 1'b0;
    f = find_sync(0, FS);
    checks++; if (f < 1) begin errors++; $display("FAIL frame_fs: FS index %0d, required >=1", f); return; end
    checks++; if (cb[f-1] !== 1'b0) begin errors++; $display("FAIL frame_busy_pre: got %b required 0", cb[f-1]); end
    checks++; if (cb[f] !== 1'b1) begin errors++; $display("FAIL frame_busy_fs: got %b required 1", cb[f]); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (cs[f+k] !== SYNC_FIRST[k]) begin errors++; $display("FAIL l0_sync w%0d: got %h required %h", k, cs[f+k], SYNC_FIRST[k]); end
      checks++; if (cd[f+k] !== mk(k)) begin errors++; $display("FAIL l0_data w%0d: got %h required %h", k, cd[f+k], mk(k)); end
    end
    checks++; if (cs[f+8] !== CRC) begin errors++; $display("FAIL l0_crc_sync: got %h required %h", cs[f+8], CRC); end
    checks++; if (cd[f+8] !== ONES) begin errors++; $display("FAIL l0_crc_data: got %h required %h", cd[f+8], ONES); end
    g = 0;
    while (f + 9 + g < cs.size() && cs[f+9+g] == TR) g++;
    checks++; if (g < 67) begin errors++; $display("FAIL hblank_len: got %0d required >=67", g); end
    l = f + 9 + g;
    checks++; if (cs[l] !== LS) begin errors++; $display("FAIL l1_ls: got %h required %h", cs[l], LS); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (cs[l+k] !== SYNC_LAST[k]) begin errors++; $display("FAIL l1_sync w%0d: got %h required %h", k, cs[l+k], SYNC_LAST[k]); end
      checks++; if (cd[l+k] !== mk(8+k)) begin errors++; $display("FAIL l1_data w%0d: got %h required %h", k, cd[l+k], mk(8+k)); end
    end
    checks++; if (cs[l+8] !== CRC) begin errors++; $display("FAIL l1_crc: got %h required %h", cs[l+8], CRC); end
    checks++; if (cb[l+8] !== 1'b1) begin errors++; $display("FAIL busy_last_crc: got %b required 1", cb[l+8]); end
    checks++; if (cs[l+9] !== TR) begin errors++; $display("FAIL vblank_after: got %h required %h", cs[l+9], TR); end
    checks++; if (cb[l+9] !== 1'b0) begin errors++; $display("FAIL busy_after: got %b required 0", cb[l+9]); end
  endtask

  task automatic test_drop();
    int f, junk;
    param_width = 16'd8; param_height = 16'd1;
    for (int i = 0; i < 3; i++) begin
      b_dat[i] = mk(100+i); b_user[i] = 1'b0; b_last[i] = 1'b0; b_gap[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      b_dat[3+i] = mk(i); b_user[3+i] = (i == 0); b_last[3+i] = (i == 7); b_gap[3+i] = 0;
    end
    start_cap();
    drive(11);
    repeat (12) begin @(posedge aclk); #1; end
    cap_on = 1'b0;
    f = find_sync(0, FS);
    checks++; if (f < 0) begin errors++; $display("FAIL drop_fs: FS index %0d, required found", f); return; end
    junk = 0;
    for (int j = 0; j < f; j++) if (cs[j] !== TR || cd[j] !== TR4) junk++;
    checks++; if (junk != 0) begin errors++; $display("FAIL drop_leak: %0d non-training words before FS, required 0", junk); end
    checks++; if (cd[f] !== mk(0)) begin errors++; $display("FAIL drop_fs_data: got %h required %h", cd[f], mk(0)); end
    checks++; if (cs[f+6] !== FE) begin errors++; $display("FAIL drop_fe: got %h required %h", cs[f+6], FE); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL clean_underrun: got %b required 0", underrun); end
    checks++; if (tlast_error !== 1'b0) begin errors++; $display("FAIL clean_tlast: got %b required 0", tlast_error); end
  endtask

  task automatic test_underrun();
    int f;
    param_width = 16'd8; param_height = 16'd1;
    set_beats(6, 6);
    b_gap[3] = 2;
    start_cap();
    drive(6);
    repeat (12) begin @(posedge aclk); #1; end
    cap_on = 1'b0;
    f = find_sync(0, FS);
    checks++; if (f < 0) begin errors++; $display("FAIL und_fs: FS index %0d, required found", f); return; end
    for (int k = 0; k < 8; k++) begin
      checks++; if (cs[f+k] !== SYNC_ONLY[k]) begin errors++; $display("FAIL und_sync w%0d: got %h required %h", k, cs[f+k], SYNC_ONLY[k]); end
      checks++; if (cd[f+k] !== mk(UND_IDX[k])) begin errors++; $display("FAIL und_data w%0d: got %h required %h", k, cd[f+k], mk(UND_IDX[k])); end
    end
    checks++; if (cs[f+8] !== CRC) begin errors++; $display("FAIL und_crc: got %h required %h", cs[f+8], CRC); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL und_flag: got %b required 1", underrun); end
    checks++; if (tlast_error !== 1'b0) begin errors++; $display("FAIL und_tlast: got %b required 0", tlast_error); end
  endtask

  task automatic test_tlast_early();
    int f;
    param_width = 16'd8; param_height = 16'd2;
    set_beats(16, 8);
    b_last[5] = 1'b1;
    start_cap();
    drive(16);
    repeat (12) begin @(posedge aclk); #1; end
    cap_on = 1'b0;
    f = find_sync(0, FS);
    checks++; if (f < 0) begin errors++; $display("FAIL tle_fs: FS index %0d, required found", f); return; end
    checks++; if (cs[f+6] !== LE) begin errors++; $display("FAIL tle_le: got %h required %h", cs[f+6], LE); end
    checks++; if (cs[f+7] !== ID) begin errors++; $display("FAIL tle_id: got %h required %h", cs[f+7], ID); end
    checks++; if (cd[f+7] !== mk(7)) begin errors++; $display("FAIL tle_w7_data: got %h required %h", cd[f+7], mk(7)); end
    checks++; if (cs[f+8] !== CRC) begin errors++; $display("FAIL tle_crc: got %h required %h", cs[f+8], CRC); end
    checks++; if (tlast_error !== 1'b1) begin errors++; $display("FAIL tle_flag: got %b required 1", tlast_error); end
  endtask

  task automatic test_tlast_missing();
    int f;
    do_reset();
    checks++; if (tlast_error !== 1'b0) begin errors++; $display("FAIL tlm_pre: got %b required 0", tlast_error); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL tlm_und_cleared: got %b required 0", underrun); end
    param_width = 16'd8; param_height = 16'd1;
    set_beats(8, 8);
    b_last[7] = 1'b0;
    start_cap();
    drive(8);
    repeat (12) begin @(posedge aclk); #1; end
    cap_on = 1'b0;
    f = find_sync(0, FS);
    checks++; if (f < 0) begin errors++; $display("FAIL tlm_fs: FS index %0d, required found", f); return; end
    checks++; if (cs[f+7] !== ID) begin errors++; $display("FAIL tlm_id: got %h required %h", cs[f+7], ID); end
    checks++; if (tlast_error !== 1'b1) begin errors++; $display("FAIL tlm_flag: got %b required 1", tlast_error); end
  endtask

  task automatic test_reset_midline();
    int bi, wcnt, n, bad;
    logic acc, ls_seen;
    param_width = 16'd8; param_height = 16'd2;
    set_beats(16, 8);
    bi = 0; wcnt = 0; ls_seen = 1'b0;
    for (n = 0; n < 2000; n++) begin
      if (bi < 16) begin
        tdata = b_dat[bi]; tuser = b_user[bi]; tlast = b_last[bi]; tvalid = 1'b1;
      end else begin
        tvalid = 1'b0;
      end
      #1 acc = tvalid & tready;
      @(posedge aclk); #1;
      if (acc) bi++;
      if (!ls_seen && m_sync == LS) begin ls_seen = 1'b1; wcnt = 0; end
      else if (ls_seen) wcnt++;
      if (ls_seen && wcnt == 4) break;
    end
    checks++; if (!(ls_seen && wcnt == 4)) begin errors++; $display("FAIL mid_reach: ls_seen=%0b w=%0d, required line1 w4", ls_seen, wcnt); end
    checks++; if (m_sync !== IMG) begin errors++; $display("FAIL mid_w4_sync: got %h required %h", m_sync, IMG); end
    aresetn = 1'b0;
    #1;
    checks++; if (m_sync !== TR) begin errors++; $display("FAIL mid_rst_sync: got %h required %h", m_sync, TR); end
    checks++; if (m_data !== TR4) begin errors++; $display("FAIL mid_rst_data: got %h required %h", m_data, TR4); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
    checks++; if (tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready: got %b required 0", tready); end
    tdata = mk(0); tuser = 1'b1; tlast = 1'b0; tvalid = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk); aresetn = 1'b1;
    bad = 0;
    for (n = 1; n <= 3000; n++) begin
      @(posedge aclk); #1;
      if (m_sync == FS) break;
      if (m_sync !== TR || m_data !== TR4) bad++;
    end
    tvalid = 1'b0; tuser = 1'b0;
    checks++; if (n < 2000 || n > 2002) begin errors++; $display("FAIL mid_fs_delay: FS after %0d cycles, required 2000..2002", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_training: %0d non-training words, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drop();
    test_underrun();
    test_tlast_early();
    test_tlast_missing();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/python_sync_encoder.md
Name: python_sync_encoder

Overview:
- Transmit-side encoder for the PYTHON sensor LVDS word format, for sensor emulation and loopback.
- Converts an AXI4-Stream of 4-pixel × 10-bit beats into a continuous parallel word stream of 4 data lanes plus one sync lane, one 10-bit word per lane per aclk.
- Inserts training, frame/line start, ID, image, end and CRC codes in the same framing the receive path decodes.
- Sits upstream of the 10:1 serializers.

Parameters:
LANES, 4, data lanes per word
DATA_BITS, 10, bits per lane word
INIT_TRAIN, 2000, training words after reset before the first frame
H_BLANK, 67, minimum training words after each line's CRC word
V_BLANK, 256, minimum training words between frame end and next frame start
TR_CODE, 10'h3a6, training code (sync lane and all data lanes)
FS_CODE/LS_CODE/LE_CODE/FE_CODE, 10'h2aa/10'h0aa/10'h12a/10'h3aa, frame start / line start / line end / frame end
IMG_CODE/ID_CODE/CRC_CODE, 10'h035/10'h000/10'h059, image / ID / CRC sync codes

Ports:
aresetn  in  1  asynchronous active-low reset
aclk  in  1  clock, one output word per cycle
enable  in  1  start new frames; sampled only at frame boundary
param_width  in  16  words per line (pixels/4), ≥5
param_height  in  16  lines per frame, ≥1
s_axi4s_tuser  in  1  first beat of frame
s_axi4s_tlast  in  1  last beat of line
s_axi4s_tdata  in  LANES*DATA_BITS  lane0 in [9:0]
s_axi4s_tvalid  in  1  beat valid
s_axi4s_tready  out  1  beat accept
m_data  out  LANES*DATA_BITS  data lane words, MSB sent first by the serializer
m_sync  out  DATA_BITS  sync lane word
busy  out  1  frame in progress
underrun  out  1  sticky: tvalid low during a line
tlast_error  out  1  sticky: tlast position ≠ param_width-1

Behaviour:
- Reset (async assert, sync release): state INIT, counters 0; m_sync=TR_CODE; all m_data lanes=TR_CODE; tready=0; busy=0; underrun=0; tlast_error=0.
- Reset mid-line aborts the line immediately; the next frame starts only after a full INIT_TRAIN.
- States:
  - INIT: emit training for INIT_TRAIN words, then go to VBLANK with the blank count already satisfied.
  - VBLANK: emit training. Once ≥V_BLANK words have been emitted since frame end and enable=1:
    - beat with tvalid&tuser: tready=1, take it as word 0 of line 0, go to LINE.
    - beat with tvalid&!tuser: dropped (tready=1), stay in VBLANK.
  - LINE: word index w=0..param_width-1, one word per cycle; tready=1 throughout; m_data = beat tdata.
  - CRC: one word; m_data lanes=10'h3ff, m_sync=CRC_CODE. Then HBLANK, or VBLANK if this was the last line.
  - HBLANK: emit training for ≥H_BLANK words. Then wait for tvalid (tuser ignored) and accept it as word 0 of the next line.
- Sync code by word index w:
  - w=0: FS_CODE on line 0, otherwise LS_CODE.
  - w=1: ID_CODE.
  - 2..W-3: IMG_CODE.
  - W-2: FE_CODE on the last line (line==param_height-1), otherwise LE_CODE.
  - W-1: ID_CODE.
- param_width and param_height are latched at frame start and ignore changes mid-frame.
- Latency: a beat accepted at cycle n appears on m_data/m_sync at cycle n+1 (registered outputs). No bubbles on the output ever.
- Underrun: tvalid=0 while in LINE:
  - repeat the previous m_data, still advance w and emit the position's sync code;
  - set underrun.
- tlast:
  - tlast=1 at w<W-1: set tlast_error; the line still runs to param_width words, with missing words treated as underrun.
  - tlast=0 at w=W-1: set tlast_error.
  - Line length is never shortened.
- tuser=1 on a beat other than frame start's word 0: the beat is accepted as pixel data and tuser is ignored.
- busy=1 from FS word output through the CRC word of the last line.
- Line counter wraps to 0 after the last line. The word counter is 16-bit and wraps at param_width.

Test Plan:
- Reset release, tvalid=0 → exactly 2000 words with m_sync=3a6 and m_data=3a6 per lane, then continuous training; tready=0.
- width=8, height=2, gapless input beats d0..d15 (tuser on d0, tlast on d7/d15):
  - line 0 sync: 2aa,000,035,035,035,035,12a,000, then 059 with data 3ff, then ≥67 training words;
  - line 1 sync ends with 3aa,000;
  - m_data equals each beat one cycle after acceptance.
- Before frame start, three beats with tuser=0, then a tuser beat → the three beats are dropped (tready=1) and the frame starts with FS on the tuser beat.
- width=8, tvalid dropped for 2 cycles at w=3 → output stays 8 words, m_data repeats the w=2 data, underrun=1 sticky.
- width=8, tlast on w=5 → tlast_error=1, still 8 words with LE at w=6; tlast absent at w=7 on the next line also sets the flag.
- aresetn pulsed low at w=4 of line 1 → outputs return to training immediately; next FS appears ≥2000 words later.
